fp_addsub_seq: RTL and testbench

FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

---
 rtl/fp_pkg.sv | 37 +++
 rtl/fp_lzc.sv | 18 +
 rtl/fp_addsub_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the binary32 add/subtract unit.
//   - binary32 field widths, exponent bias, maximum exponent
//   - canonical quiet NaN
//   - sequencer state encoding
//   - align_shift: right shift of a significand into a 27-bit guard/round/sticky field
package fp_pkg;

    localparam int          EXP_W    = 8;
    localparam int          FRAC_W   = 23;
    localparam int          BIAS     = 127;
    localparam int          EXP_MAX  = 255;
    localparam logic [31:0] QNAN_DEF = 32'h7FC00000;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADDSUB,
        NORM,
        ROUND,
        DONE
    } state_t;

    // {sig, G, R, S} shifted right by d. Every bit pushed past the sticky
    // position is ORed into it, so a shift of 27 or more leaves only sticky.
    function automatic logic [26:0] align_shift(input logic [FRAC_W:0] sig,
                                                input logic [EXP_W-1:0] d);
        logic [26:0] ext;
        logic [26:0] mask;
        ext = {sig, 3'b000};
        if (d >= 8'd27) begin
            return {26'd0, |sig};
        end
        mask = ~(27'h7FFFFFF << d);
        return (ext >> d) | {26'd0, |(ext & mask)};
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter over a 28-bit value, used during normalisation.
// Ports:
//   din  in   28  value to scan
//   cnt  out  5   number of zeros above the most significant one (28 if din == 0)
module fp_lzc (
    input  logic [27:0] din,
    output logic [4:0]  cnt
);

    // The highest set bit is the last one seen in an ascending scan.
    always_comb begin
        cnt = 5'd28;
        for (int i = 0; i < 28; i++) begin
            if (din[i]) cnt = 5'(27 - i);
        end
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 binary32 adder/subtractor, round-to-nearest-even,
// full denormal support. One operation walks IDLE-ALIGN-ADDSUB-NORM-ROUND-DONE.
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   operand pair presented
//   in_ready   out  1   high in IDLE only
//   a, b       in   32  binary32 operands
//   op         in   1   0 = a+b, 1 = a-b
//   out_valid  out  1   high in DONE only
//   out_ready  in   1   result consumed
//   s          out  32  binary32 result (registered)
//   flags      out  3   {invalid, overflow, inexact} (registered)
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter logic [31:0] QNAN = QNAN_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] s,
    output logic [2:0]  flags
);

    state_t state, state_nxt;

    // Operand registers; rb already carries the effective (op-adjusted) sign.
    logic [31:0] ra, rb;

    // Datapath registers, each written in exactly one stage.
    logic        sgn, zsign, sub_r;
    logic [9:0]  exp_r;
    logic [26:0] mb, ms, m_n;
    logic [27:0] sum_r;
    logic        spec_r;
    logic [31:0] spec_s;
    logic [2:0]  spec_f;
    logic [31:0] s_r;
    logic [2:0]  flags_r;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ALIGN;
            end
            ALIGN:  state_nxt = ADDSUB;
            ADDSUB: state_nxt = NORM;
            NORM:   state_nxt = ROUND;
            ROUND:  state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- ALIGN ----------------
    logic [EXP_W-1:0]  ea, eb, eea, eeb, e_big, e_sml;
    logic [FRAC_W-1:0] fa, fb;
    logic [FRAC_W:0]   siga, sigb;
    logic a_nan, b_nan, a_inf, b_inf, a_snan, b_snan, a_big, eff_sub, inf_inf;
    logic        spec_c;
    logic [31:0] spec_s_c;
    logic [2:0]  spec_f_c;

    assign ea      = ra[30:23];
    assign eb      = rb[30:23];
    assign fa      = ra[22:0];
    assign fb      = rb[22:0];
    assign a_nan   = (&ea) && (|fa);
    assign b_nan   = (&eb) && (|fb);
    assign a_inf   = (&ea) && !(|fa);
    assign b_inf   = (&eb) && !(|fb);
    assign a_snan  = a_nan && !fa[22];
    assign b_snan  = b_nan && !fb[22];
    assign eff_sub = ra[31] ^ rb[31];
    assign inf_inf = a_inf && b_inf && eff_sub;

    // Denormals: hidden bit 0, effective exponent 1.
    assign eea  = (ea == 8'd0) ? 8'd1 : ea;
    assign eeb  = (eb == 8'd0) ? 8'd1 : eb;
    assign siga = {ea != 8'd0, fa};
    assign sigb = {eb != 8'd0, fb};

    // {exp, frac} ordering equals magnitude ordering for all finite values.
    assign a_big = (ra[30:0] >= rb[30:0]);
    assign e_big = a_big ? eea : eeb;
    assign e_sml = a_big ? eeb : eea;

    always_comb begin
        spec_c   = 1'b0;
        spec_s_c = 32'd0;
        spec_f_c = 3'b000;
        if (a_nan || b_nan || inf_inf) begin
            spec_c   = 1'b1;
            spec_s_c = QNAN;
            spec_f_c = {a_snan | b_snan | inf_inf, 2'b00};
        end else if (a_inf) begin
            spec_c   = 1'b1;
            spec_s_c = ra;
        end else if (b_inf) begin
            spec_c   = 1'b1;
            spec_s_c = rb;
        end
    end

    // ---------------- NORM ----------------
    logic [4:0] lz;
    logic [9:0] lsh, lim, nsh;

    fp_lzc u_lzc (
        .din (sum_r),
        .cnt (lz)
    );

    // The leading one belongs at bit 26; the shift stops once exponent hits 1,
    // which leaves a denormal with bit 26 clear.
    assign lsh = {5'd0, lz} - 10'd1;
    assign lim = exp_r - 10'd1;
    assign nsh = (lsh < lim) ? lsh : lim;

    // ---------------- ROUND ----------------
    logic        g, rbit, st, rup;
    logic [24:0] mant25;
    logic [23:0] mant_f;
    logic [9:0]  exp_rnd;
    logic [31:0] res_s;
    logic [2:0]  res_f;

    assign g       = m_n[2];
    assign rbit    = m_n[1];
    assign st      = m_n[0];
    assign rup     = g & (rbit | st | m_n[3]);
    assign mant25  = {1'b0, m_n[26:3]} + {24'd0, rup};
    assign exp_rnd = exp_r + {9'd0, mant25[24]};
    assign mant_f  = mant25[24] ? mant25[24:1] : mant25[23:0];

    always_comb begin
        res_s = {sgn, (mant_f[23] ? exp_rnd[7:0] : 8'd0), mant_f[22:0]};
        res_f = {2'b00, g | rbit | st};
        if (spec_r) begin
            res_s = spec_s;
            res_f = spec_f;
        end else if (m_n == 27'd0) begin
            res_s = {zsign, 31'd0};
            res_f = 3'b000;
        end else if (exp_rnd >= 10'(EXP_MAX)) begin
            res_s = {sgn, 8'hFF, 23'd0};
            res_f = 3'b011;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ra      <= 32'd0;
            rb      <= 32'd0;
            sgn     <= 1'b0;
            zsign   <= 1'b0;
            sub_r   <= 1'b0;
            exp_r   <= 10'd1;
            mb      <= 27'd0;
            ms      <= 27'd0;
            m_n     <= 27'd0;
            sum_r   <= 28'd0;
            spec_r  <= 1'b0;
            spec_s  <= 32'd0;
            spec_f  <= 3'b000;
            s_r     <= 32'd0;
            flags_r <= 3'b000;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    ra <= a;
                    rb <= {b[31] ^ op, b[30:0]};
                end
                ALIGN: begin
                    sgn    <= a_big ? ra[31] : rb[31];
                    // Only like-signed zeros keep a negative sign on an exact zero.
                    zsign  <= ~eff_sub & ra[31];
                    sub_r  <= eff_sub;
                    exp_r  <= {2'b00, e_big};
                    mb     <= {(a_big ? siga : sigb), 3'b000};
                    ms     <= align_shift(a_big ? sigb : siga, e_big - e_sml);
                    spec_r <= spec_c;
                    spec_s <= spec_s_c;
                    spec_f <= spec_f_c;
                end
                ADDSUB: begin
                    // mb >= ms, so the difference never goes negative.
                    sum_r <= sub_r ? ({1'b0, mb} - {1'b0, ms}) : ({1'b0, mb} + {1'b0, ms});
                end
                NORM: begin
                    if (sum_r[27]) begin
                        m_n   <= {sum_r[27:2], |sum_r[1:0]};
                        exp_r <= exp_r + 10'd1;
                    end else begin
                        m_n   <= sum_r[26:0] << nsh;
                        exp_r <= exp_r - nsh;
                    end
                end
                ROUND: begin
                    s_r     <= res_s;
                    flags_r <= res_f;
                end
                default: ;
            endcase
        end
    end

    assign s     = s_r;
    assign flags = flags_r;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed + random bench for fp_addsub_seq. Expected results come from an
// exact wide-integer reference, queued at drive time and popped on out_valid.
module tb_fp_addsub_seq;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] s;
    logic [2:0]  flags;

    int n_vec = 0;
    int n_err = 0;
    logic [34:0] sb_q[$];

    always #5 clk = ~clk;

    fp_addsub_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .flags     (flags)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Exact reference: both operands scaled to a common integer grid, summed
    // exactly, then rounded to nearest-even. Returns {flags, s}.
    function automatic logic [34:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic o);
        logic sx, sy, sr, nx, ny, ix, iy, snan, up, inx;
        logic [7:0] ex, ey;
        logic [22:0] fx, fy;
        logic [299:0] mx, my, r, q, rem, half;
        int exa, eya, emin, p, be, sh;
        sx = x[31]; sy = y[31] ^ o;
        ex = x[30:23]; ey = y[30:23];
        fx = x[22:0]; fy = y[22:0];
        nx = (ex == 8'hFF) && (fx != 0);
        ny = (ey == 8'hFF) && (fy != 0);
        ix = (ex == 8'hFF) && (fx == 0);
        iy = (ey == 8'hFF) && (fy == 0);
        snan = (nx && !fx[22]) || (ny && !fy[22]);
        if (nx || ny) return {snan, 2'b00, 32'h7FC00000};
        if (ix && iy && (sx != sy)) return {3'b100, 32'h7FC00000};
        if (ix) return {3'b000, x};
        if (iy) return {3'b000, sy, 8'hFF, 23'd0};
        exa = (ex == 0) ? 1 : int'(ex);
        eya = (ey == 0) ? 1 : int'(ey);
        emin = (exa < eya) ? exa : eya;
        mx = 300'({ex != 0, fx}) << (exa - emin);
        my = 300'({ey != 0, fy}) << (eya - emin);
        if (sx == sy) begin r = mx + my; sr = sx; end
        else if (mx >= my) begin r = mx - my; sr = sx; end
        else begin r = my - mx; sr = sy; end
        if (r == 0) return {3'b000, sx & sy, 31'd0};
        p = 0;
        for (int i = 0; i < 300; i++) if (r[i]) p = i;
        be = p + emin - 23;
        if (be < 1) be = 1;
        sh = be - emin;
        inx = 1'b0;
        if (sh <= 0) begin
            q = r << (-sh);
        end else begin
            q    = r >> sh;
            rem  = r & ((300'd1 << sh) - 300'd1);
            half = 300'd1 << (sh - 1);
            up   = (rem > half) || ((rem == half) && q[0]);
            inx  = (rem != 0);
            q    = q + 300'(up);
        end
        if (q[24]) begin q = q >> 1; be++; end
        if (be >= 255) return {3'b011, sr, 8'hFF, 23'd0};
        return {2'b00, inx, sr, (q[23] ? 8'(be) : 8'd0), q[22:0]};
    endfunction

    // One full transaction; hold > 0 keeps out_ready low for that many DONE cycles.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic o, input int hold);
        logic [34:0] e;
        int lat;
        sb_q.push_back(ref_add(x, y, o));
        @(negedge clk);
        a = x; b = y; op = o; in_valid = 1'b1; out_ready = (hold == 0);
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        // Scramble inputs after the accept edge; they must be ignored.
        in_valid = 1'b0; a = $urandom; b = $urandom; op = 1'($urandom);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!out_valid && lat < 20);
        chk("latency", 64'(lat), 64'd5);
        e = sb_q.pop_front();
        chk("s", s, e[31:0]);
        chk("flags", flags, e[34:32]);
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                chk("bp_hold", {in_ready, out_valid, flags, s}, {2'b01, e});
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk("back_to_idle", {in_ready, out_valid}, 2'b10);
    endtask

    logic [31:0] one, two;
    logic [31:0] rx, ry;
    logic        ov_seen;

    initial begin
        one = {1'b0, 8'(BIAS), 23'd0};
        two = {1'b0, 8'(BIAS + 1), 23'd0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", {in_ready, out_valid, flags, s}, {2'b10, 3'b000, 32'd0});
        rst = 1'b0;

        // Directed
        run_op(one, two, 1'b0, 0);                       // 1 + 2 = 3
        run_op(one, one, 1'b1, 0);                       // 1 - 1 = +0
        run_op(32'h00000001, 32'h00000001, 1'b0, 0);     // denormal sum
        run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 0);     // overflow
        run_op(32'h7F800000, 32'h7F800000, 1'b1, 0);     // inf - inf
        run_op(32'h3F800000, 32'h33800000, 1'b0, 0);     // tie to even, stays
        run_op(32'h3F800001, 32'h33800000, 1'b0, 0);     // tie to even, rounds up
        run_op(32'h80000000, 32'h80000000, 1'b0, 0);     // -0 + -0
        run_op(32'h00000000, 32'h80000000, 1'b0, 0);     // +0 + -0
        run_op(32'hFF800000, 32'h3F800000, 1'b0, 0);     // -inf + finite
        run_op(32'h7F800001, 32'h3F800000, 1'b0, 0);     // sNaN
        run_op(32'h7FC00123, 32'h3F800000, 1'b1, 0);     // qNaN
        run_op(32'h00800000, 32'h00000001, 1'b1, 0);     // normal -> denormal
        run_op(32'h4B800000, 32'h3F800000, 1'b1, 0);     // long borrow
        run_op(32'h3F800000, 32'h40000000, 1'b0, 10);    // backpressure

        // Reset during NORM
        @(negedge clk);
        a = 32'h40400000; b = one; op = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (3) @(negedge clk);                       // ALIGN, ADDSUB, NORM
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_idle", {in_ready, flags, s}, {1'b1, 3'b000, 32'd0});
        ov_seen = 1'b0;
        repeat (8) begin @(negedge clk); ov_seen |= out_valid; end
        chk("rst_mid_no_valid", ov_seen, 1'b0);
        run_op(32'h40400000, one, 1'b0, 0);

        // Random: each pair as add and subtract
        for (int i = 0; i < 500; i++) begin
            rx = $urandom;
            case ($urandom_range(0, 3))
                0: ry = $urandom;
                1: ry = {1'($urandom), 8'(int'(rx[30:23]) ^ $urandom_range(0, 1)), 23'($urandom)};
                2: begin
                    rx = {1'($urandom), 8'($urandom_range(0, 2)), 23'($urandom)};
                    ry = {1'($urandom), 8'($urandom_range(0, 2)), 23'($urandom)};
                end
                default: ry = rx ^ {1'($urandom), 26'd0, 5'($urandom)};
            endcase
            run_op(rx, ry, 1'b0, 0);
            run_op(rx, ry, 1'b1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
